voice_scheduler: RTL and testbench
==================================

Name: voice_scheduler

Overview:
- Polyphony controller between the Avalon command register and the shared sample-generation datapath.
- Decodes 16-bit note command words and keeps a table of NUM_VOICES voice slots, allocating, freeing and stealing slots as commands arrive.
- Holds the global wave select.
- On every sample tick, sequences the shared oscillator/accumulator through all active slots with a req/ack handshake, then signals frame completion.

Parameters:
- NUM_VOICES, 8, number of voice slots; must be a power of two and at least 2.
- IDX_W, 3, slot index width; equals log2(NUM_VOICES).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- i_cmd_valid  in  1  command word present; held until accepted
- i_cmd  in  16  [15]=on/off, [14:8]=note, [7:0]=velocity (ignored)
- o_cmd_ready  out  1  command accepted this cycle when i_cmd_valid & o_cmd_ready
- i_sample_tick  in  1  one-cycle pulse at the sample rate
- o_voice_req  out  1  request to the shared datapath to process one slot
- o_voice_idx  out  IDX_W  slot being requested
- o_voice_note  out  7  note of the requested slot
- i_voice_ack  in  1  datapath finished the requested slot
- o_frame_done  out  1  one-cycle pulse when all slots for a tick have been processed
- o_overrun  out  1  one-cycle pulse when a tick is dropped
- o_active_mask  out  NUM_VOICES  bit n set = slot n playing
- o_wave_sel  out  1  0 = sine, 1 = square

Behaviour:
- Clocking and reset:
  - One clock. Reset is asynchronous and active-high.
  - Reset clears all outputs and registers: state IDLE, mask 0, all notes 0, wave_sel 0, steal_ptr 0, tick_pending 0.
- o_cmd_ready = (state==IDLE) & !tick_pending. Commands are never accepted during a scan, so the slot table is stable within a frame.
- An accepted command takes effect at the next clock edge (1-cycle latency to o_active_mask):
  - on, note 0: toggle wave_sel. Table unchanged.
  - on, note 1..127, note already active in any slot: no change (no duplicates).
  - on, new note, a free slot exists: lowest-index free slot gets the note and its mask bit is set.
  - on, new note, all slots full: overwrite slot steal_ptr, then steal_ptr = steal_ptr+1 mod NUM_VOICES. steal_ptr advances only on a steal.
  - off, note 127: clear the entire mask. Notes are left stale; steal_ptr is unchanged.
  - off, note matching an active slot: clear that slot's mask bit.
  - off, note not playing (or note 0): ignored.
- FSM states IDLE, CHECK, REQ:
  - IDLE:
    - i_sample_tick or tick_pending -> CHECK with idx=0; tick_pending clears.
    - If a command and a tick arrive in the same IDLE cycle: the command is applied and the tick is latched into tick_pending. The scan starts the following cycle and sees the updated table.
  - CHECK: one cycle per slot.
    - Slot active -> REQ.
    - Slot inactive and idx < NUM_VOICES-1 -> idx+1, stay in CHECK.
    - Slot inactive and idx is the last slot -> pulse o_frame_done, go to IDLE.
  - REQ:
    - o_voice_req=1 with idx and note stable until i_voice_ack is sampled high.
    - On ack: deassert req. If idx is the last slot -> pulse o_frame_done, go to IDLE; else idx+1, go to CHECK.
    - Ack in the same cycle req rises is accepted.
    - i_voice_ack outside REQ is ignored.
- Tick outside IDLE:
  - If tick_pending==0, set it.
  - If already pending, the tick is dropped and o_overrun pulses for 1 cycle.
- Empty table: a tick walks all NUM_VOICES slots with no req and pulses o_frame_done after NUM_VOICES+1 cycles.
- Mid-operation reset: req drops immediately, no frame_done is issued, table is cleared.
- o_frame_done and o_overrun are registered single-cycle pulses.

Test Plan:
- Reset, then cmd 0xC500 (on A4, note 0x45) -> next cycle mask=0x01, slot0 note=0x45. Repeat 0xC500 -> mask stays 0x01. Send 0x4900 (off, not playing) -> no change. Send 0x4500 -> mask=0x00.
- On notes 0x20..0x27 -> mask=0xFF. On 0x30 -> slot0=0x30, steal_ptr=1. On 0x31 -> slot1=0x31, steal_ptr=2.
- Cmd 0x8000 -> wave_sel=1. Cmd 0x8000 again -> wave_sel=0, mask unaffected. Cmd 0x7F00 -> mask=0x00.
- mask=0x05, tick, ack delayed 3 cycles per req -> req idx0, then idx2 (slot1 skipped, no req). Exactly one frame_done. o_cmd_ready=0 throughout. A command held valid is accepted only after return to IDLE.
- Tick during a scan -> new scan starts immediately after frame_done. Third tick before that -> o_overrun pulses once. Empty table tick -> frame_done after 9 cycles with no req.
- Assert reset while in REQ -> req, mask and wave_sel are 0 asynchronously. No frame_done. First post-reset tick scans normally.

Source files
------------

// File: rtl/voice_scheduler.sv
// voice_scheduler: decodes note commands into a slot table and, on each
// sample tick, walks the active slots through the shared datapath.
module voice_scheduler #(
  parameter int NUM_VOICES = 8,
  parameter int IDX_W      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_cmd_valid,
  input  logic [15:0]           i_cmd,
  output logic                  o_cmd_ready,
  input  logic                  i_sample_tick,
  output logic                  o_voice_req,
  output logic [IDX_W-1:0]      o_voice_idx,
  output logic [6:0]            o_voice_note,
  input  logic                  i_voice_ack,
  output logic                  o_frame_done,
  output logic                  o_overrun,
  output logic [NUM_VOICES-1:0] o_active_mask,
  output logic                  o_wave_sel
);

  typedef enum logic [1:0] {IDLE, CHECK, REQ} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_VOICES - 1);

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        steal_ptr;
  logic [NUM_VOICES-1:0]   mask;
  logic [6:0]              notes [NUM_VOICES];
  logic                    wave_sel;
  logic                    tick_pending;
  logic                    voice_req;
  logic                    frame_done;
  logic                    overrun;

  logic                    cmd_on;
  logic [6:0]              cmd_note;
  logic                    cmd_accept;
  logic [NUM_VOICES-1:0]   match_mask;
  logic                    free_found;
  logic [IDX_W-1:0]        free_idx;
  logic                    unused_velocity;

  assign cmd_on          = i_cmd[15];
  assign cmd_note        = i_cmd[14:8];
  assign unused_velocity = ^i_cmd[7:0];
  assign o_cmd_ready     = (state == IDLE) && !tick_pending;
  assign cmd_accept      = i_cmd_valid && o_cmd_ready;

  // Active slots holding the commanded note, and the lowest free slot
  always_comb begin
    match_mask = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      match_mask[i] = mask[i] && (notes[i] == cmd_note);
    end
    // Scan downward so the last hit is the lowest free index
    for (int unsigned i = NUM_VOICES; i > 0; i--) begin
      if (!mask[i-1]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i - 1);
      end
    end
  end

  // Slot table, wave select and steal pointer updated by accepted commands
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask      <= '0;
      wave_sel  <= 1'b0;
      steal_ptr <= '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        notes[i] <= '0;
      end
    end else if (cmd_accept) begin
      if (cmd_on) begin
        if (cmd_note == 7'd0) begin
          wave_sel <= ~wave_sel;
        end else if (|match_mask) begin
          // already playing: no duplicates
        end else if (free_found) begin
          notes[free_idx] <= cmd_note;
          mask[free_idx]  <= 1'b1;
        end else begin
          notes[steal_ptr] <= cmd_note;
          mask[steal_ptr]  <= 1'b1;
          steal_ptr        <= steal_ptr + 1'b1;
        end
      end else begin
        if (cmd_note == 7'h7F) begin
          mask <= '0;
        end else if (cmd_note != 7'd0) begin
          mask <= mask & ~match_mask;
        end
      end
    end
  end

  // Scan sequencer: walks slots per tick, handshakes active ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      tick_pending <= 1'b0;
      voice_req    <= 1'b0;
      frame_done   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      if ((state != IDLE) && i_sample_tick) begin
        if (!tick_pending) tick_pending <= 1'b1;
        else               overrun      <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (i_sample_tick && cmd_accept) begin
            // command wins this cycle; scan starts next cycle on new table
            tick_pending <= 1'b1;
          end else if (i_sample_tick || tick_pending) begin
            state        <= CHECK;
            idx          <= '0;
            tick_pending <= i_sample_tick && tick_pending;
          end
        end
        CHECK: begin
          if (mask[idx]) begin
            state     <= REQ;
            voice_req <= 1'b1;
          end else if (idx == LAST) begin
            frame_done <= 1'b1;
            state      <= IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        REQ: begin
          if (i_voice_ack) begin
            voice_req <= 1'b0;
            if (idx == LAST) begin
              frame_done <= 1'b1;
              state      <= IDLE;
            end else begin
              idx   <= idx + 1'b1;
              state <= CHECK;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_voice_req   = voice_req;
  assign o_voice_idx   = idx;
  assign o_voice_note  = notes[idx];
  assign o_frame_done  = frame_done;
  assign o_overrun     = overrun;
  assign o_active_mask = mask;
  assign o_wave_sel    = wave_sel;

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler with hand-computed expectations.
module tb_voice_scheduler;

  localparam int NV = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_cmd_valid;
  logic [15:0]   i_cmd;
  logic          o_cmd_ready;
  logic          i_sample_tick;
  logic          o_voice_req;
  logic [IW-1:0] o_voice_idx;
  logic [6:0]    o_voice_note;
  logic          i_voice_ack;
  logic          o_frame_done;
  logic          o_overrun;
  logic [NV-1:0] o_active_mask;
  logic          o_wave_sel;

  always #5 clk = ~clk;

  voice_scheduler #(.NUM_VOICES(NV), .IDX_W(IW)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_cmd_valid   (i_cmd_valid),
    .i_cmd         (i_cmd),
    .o_cmd_ready   (o_cmd_ready),
    .i_sample_tick (i_sample_tick),
    .o_voice_req   (o_voice_req),
    .o_voice_idx   (o_voice_idx),
    .o_voice_note  (o_voice_note),
    .i_voice_ack   (i_voice_ack),
    .o_frame_done  (o_frame_done),
    .o_overrun     (o_overrun),
    .o_active_mask (o_active_mask),
    .o_wave_sel    (o_wave_sel)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int frame_cnt   = 0;
  int overrun_cnt = 0;
  int cycle       = 0;
  int ack_delay   = 0;
  int ack_wait    = 0;
  logic prev_req  = 1'b0;
  int req_idx[$];
  int req_note[$];
  int req_cyc[$];
  int frame_cyc[$];
  int ready_at_frame[$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_log();
    req_idx.delete();
    req_note.delete();
    req_cyc.delete();
  endtask

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic send_cmd(input logic [15:0] c);
    int t;
    t = 0;
    i_cmd       = c;
    i_cmd_valid = 1'b1;
    while (!o_cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check($sformatf("cmd_ready_%h", c), int'(o_cmd_ready), 1);
    @(posedge clk);
    @(negedge clk);
    i_cmd_valid = 1'b0;
  endtask

  task automatic note_on(input logic [6:0] n);
    send_cmd({1'b1, n, 8'h00});
  endtask

  task automatic pulse_tick();
    i_sample_tick = 1'b1;
    @(negedge clk);
    i_sample_tick = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int max_cycles, input string tag);
    int t;
    t = 0;
    while (frame_cnt < target && t < max_cycles) begin
      @(negedge clk);
      t++;
    end
    check(tag, frame_cnt, target);
  endtask

  initial begin
    int fb;
    int ob;
    int t;
    int cnt;
    int rdy_hi;
    int exp_notes [8];

    reset         = 1'b1;
    i_cmd_valid   = 1'b0;
    i_cmd         = '0;
    i_sample_tick = 1'b0;
    i_voice_ack   = 1'b0;

    fork
      // output monitor, sampled just after each active edge
      forever begin
        @(posedge clk);
        #1;
        cycle++;
        if (o_frame_done) begin
          frame_cnt++;
          frame_cyc.push_back(cycle);
          ready_at_frame.push_back(int'(o_cmd_ready));
        end
        if (o_overrun) overrun_cnt++;
        if (o_voice_req && !prev_req) begin
          req_idx.push_back(int'(o_voice_idx));
          req_note.push_back(int'(o_voice_note));
          req_cyc.push_back(cycle);
        end
        prev_req = o_voice_req;
      end
      // datapath model: acks each request after ack_delay cycles
      forever begin
        @(negedge clk);
        if (o_voice_req && !i_voice_ack) begin
          ack_wait++;
          if (ack_wait >= ack_delay) begin
            i_voice_ack = 1'b1;
            ack_wait    = 0;
          end
        end else begin
          i_voice_ack = 1'b0;
          if (!o_voice_req) ack_wait = 0;
        end
      end
      begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
      end
    join_none

    // reset state
    repeat (3) @(negedge clk);
    check("rst_mask", int'(o_active_mask), 0);
    check("rst_wave", int'(o_wave_sel), 0);
    check("rst_req", int'(o_voice_req), 0);
    check("rst_frame", int'(o_frame_done), 0);
    check("rst_overrun", int'(o_overrun), 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", int'(o_cmd_ready), 1);

    // allocate, duplicate, ignored off, matching off
    send_cmd(16'hC500);
    check("on_a4_mask", int'(o_active_mask), 8'h01);
    send_cmd(16'hC500);
    check("dup_mask", int'(o_active_mask), 8'h01);
    send_cmd(16'h4900);
    check("off_idle_mask", int'(o_active_mask), 8'h01);
    clear_log();
    fb = frame_cnt;
    pulse_tick();
    wait_frames(fb + 1, 100, "scan_a4_frame");
    check("scan_a4_nreq", req_idx.size(), 1);
    check("scan_a4_idx", req_idx[0], 0);
    check("scan_a4_note", req_note[0], 8'h45);
    send_cmd(16'h4500);
    check("off_a4_mask", int'(o_active_mask), 8'h00);

    // fill table, then steal
    for (int n = 8'h20; n <= 8'h27; n++) note_on(7'(n));
    check("full_mask", int'(o_active_mask), 8'hFF);
    note_on(7'h30);
    note_on(7'h31);
    check("steal_mask", int'(o_active_mask), 8'hFF);
    exp_notes = '{8'h30, 8'h31, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27};
    clear_log();
    fb = frame_cnt;
    pulse_tick();
    wait_frames(fb + 1, 200, "scan_full_frame");
    check("scan_full_nreq", req_idx.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("scan_full_idx%0d", i), req_idx[i], i);
      check($sformatf("scan_full_note%0d", i), req_note[i], exp_notes[i]);
    end
    note_on(7'h32);
    note_on(7'h32);
    note_on(7'h33);
    clear_log();
    fb = frame_cnt;
    pulse_tick();
    wait_frames(fb + 1, 200, "scan_steal_frame");
    check("steal_slot2", req_note[2], 8'h32);
    check("steal_slot3", req_note[3], 8'h33);
    check("steal_slot4", req_note[4], 8'h24);

    // wave select toggles, all-notes-off
    send_cmd(16'h8000);
    check("wave_on", int'(o_wave_sel), 1);
    check("wave_mask_kept", int'(o_active_mask), 8'hFF);
    send_cmd(16'h8000);
    check("wave_off", int'(o_wave_sel), 0);
    check("wave_mask_kept2", int'(o_active_mask), 8'hFF);
    send_cmd(16'h7F00);
    check("all_off_mask", int'(o_active_mask), 8'h00);

    // sparse table, delayed acks, command held during scan
    note_on(7'h40);
    note_on(7'h41);
    note_on(7'h42);
    send_cmd(16'h4100);
    check("sparse_mask", int'(o_active_mask), 8'h05);
    ack_delay = 3;
    clear_log();
    fb = frame_cnt;
    pulse_tick();
    i_cmd       = 16'hC400;
    i_cmd_valid = 1'b1;
    rdy_hi      = 0;
    t           = 0;
    while (frame_cnt == fb && t < 200) begin
      if (o_cmd_ready) rdy_hi++;
      @(negedge clk);
      t++;
    end
    check("sparse_frame", frame_cnt, fb + 1);
    check("sparse_ready_in_scan", rdy_hi, 0);
    check("held_cmd_not_yet", int'(o_active_mask), 8'h05);
    @(negedge clk);
    i_cmd_valid = 1'b0;
    check("held_cmd_applied", int'(o_active_mask), 8'h07);
    check("sparse_nreq", req_idx.size(), 2);
    check("sparse_idx0", req_idx[0], 0);
    check("sparse_note0", req_note[0], 8'h40);
    check("sparse_idx1", req_idx[1], 2);
    check("sparse_note1", req_note[1], 8'h42);
    repeat (3) @(negedge clk);
    check("sparse_one_frame", frame_cnt, fb + 1);

    // tick during scan queues a scan, third tick overruns
    clear_log();
    fb = frame_cnt;
    ob = overrun_cnt;
    pulse_tick();
    repeat (2) @(negedge clk);
    pulse_tick();
    repeat (2) @(negedge clk);
    pulse_tick();
    wait_frames(fb + 2, 300, "queued_frames");
    check("overrun_count", overrun_cnt - ob, 1);
    check("queued_nreq", req_idx.size(), 6);
    check("queued_restart_idx", req_idx[3], 0);
    check("queued_restart_gap", req_cyc[3] - frame_cyc[fb], 2);
    check("queued_ready_low", ready_at_frame[fb], 0);

    // empty table latency
    ack_delay = 0;
    send_cmd(16'h7F00);
    check("empty_mask", int'(o_active_mask), 8'h00);
    clear_log();
    fb = frame_cnt;
    i_sample_tick = 1'b1;
    @(negedge clk);
    i_sample_tick = 1'b0;
    cnt = 1;
    while (frame_cnt == fb && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("empty_latency", cnt, 9);
    check("empty_nreq", req_idx.size(), 0);

    // reset while a request is outstanding
    ack_delay = 100000;
    send_cmd(16'h8000);
    note_on(7'h50);
    check("pre_rst_wave", int'(o_wave_sel), 1);
    fb = frame_cnt;
    pulse_tick();
    t = 0;
    while (!o_voice_req && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("pre_rst_req", int'(o_voice_req), 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_req", int'(o_voice_req), 0);
    check("async_rst_mask", int'(o_active_mask), 0);
    check("async_rst_wave", int'(o_wave_sel), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ack_delay = 0;
    @(negedge clk);
    check("rst_no_frame", frame_cnt, fb);
    note_on(7'h51);
    clear_log();
    pulse_tick();
    wait_frames(fb + 1, 100, "post_rst_frame");
    check("post_rst_nreq", req_idx.size(), 1);
    check("post_rst_idx", req_idx[0], 0);
    check("post_rst_note", req_note[0], 8'h51);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
